pe_acc_add_stage: RTL and testbench
===================================

Name: pe_acc_add_stage

Overview:
- Parametrised next-generation add pipeline stage of the PE datapath, sitting between the multiply stage and write-back.
- Computes out_act + mult in signed two's-complement with selectable saturate/wrap arithmetic.
- Adds read-after-write forwarding from a history of recent write-back results, so back-to-back accumulations to the same activation address use the fresh value, not the stale buffer read.
- Adds pipeline stall support and an overflow event counter.

Parameters:
- DATA_W, 16, width of activation/product/result (signed), 4..32.
- ADDR_W, 6, output activation address width.
- FWD_DEPTH, 2, number of most recent issued results kept for forwarding, 1..4.
- OVF_CNT_W, 16, width of the overflow event counter.

Ports:
- clk  in  1  system clock
- rst  in  1  system reset; asynchronous, active-high
- stall  in  1  hold all stage state when high
- sat_en  in  1  1 = saturate, 0 = wrap (sampled with each op)
- ovf_clr  in  1  synchronous clear of ovf_count
- comp_en_add  in  1  op valid at add stage
- out_act_value_add  in  DATA_W  output activation value read from the buffer
- mult_result_add  in  DATA_W  multiply-stage product
- out_act_addr_add  in  ADDR_W  output activation address
- comp_en_wb  out  1  op valid at write-back
- out_act_addr_wb  out  ADDR_W  write-back address
- add_result_wb  out  DATA_W  addition result
- overflow_wb  out  1  result overflowed (clamped or wrapped)
- fwd_hit_wb  out  1  operand came from the forwarding history
- ovf_count  out  OVF_CNT_W  saturating count of overflowed ops

Behaviour:
- Reset (async, rst high): every output is 0. History entries are invalid and ovf_count is 0.
- Latency is 1 cycle: an op accepted in cycle N appears on the *_wb outputs in cycle N+1.
- Accept: an op is accepted when comp_en_add=1 and stall=0.
- Cycles with stall=0 and comp_en_add=0: comp_en_wb<=0. out_act_addr_wb, add_result_wb, overflow_wb and fwd_hit_wb hold their previous values.
- Stall=1: all registers hold, including the *_wb outputs, history and ovf_count. Exception: ovf_clr still clears ovf_count.
- History is a shift register of FWD_DEPTH entries {valid, addr, result}. Entry 0 is the newest.
  - On each accepted op, the history shifts and entry 0 is loaded with the new addr and result.
  - Non-accepted, non-stalled cycles shift in an invalid entry, so history is exactly the last FWD_DEPTH cycles.
- Operand select: A = result of the lowest-index valid history entry whose addr == out_act_addr_add. If none matches, A = out_act_value_add. fwd_hit_wb is registered with the op.
- Arithmetic: sum = A + mult_result_add computed at DATA_W+1 bits, signed. Overflow occurs when sum is outside [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - sat_en=1: clamp to max or min.
  - sat_en=0: keep the low DATA_W bits.
  - overflow_wb=1 in either mode.
- The forwarded history value is the post-saturation/wrap result, i.e. exactly what is written back.
- ovf_count increments by 1 per accepted op with overflow and sticks at all-ones.
- ovf_clr has priority over increment in the same cycle.
- Reset mid-stream: all in-flight ops and the history are dropped immediately. The first op after reset reads from out_act_value_add.

Test Plan:
- Basic, DATA_W=16, sat_en=1: ops to addr 3 (100+25), then addr 5 (-7+-8) -> results 125 then -15 with 1-cycle latency; fwd_hit_wb=0; overflow_wb=0.
- Forwarding, FWD_DEPTH=2: three consecutive ops to addr 9, stale buffer value 0, products 10, 20, 30 -> results 10, 30, 60; fwd_hit_wb sequence 0,1,1. Repeat with one idle cycle between ops -> still forwarded. Repeat with two idle cycles -> no forward, result = buffer value + product.
- Saturation: 32767+1 with sat_en=1 -> 32767, overflow_wb=1. -32768+-1 with sat_en=1 -> -32768. 32767+1 with sat_en=0 -> -32768, overflow_wb=1. ovf_count=3.
- Stall: issue an op, then hold stall=1 for 3 cycles while toggling inputs -> *_wb outputs and history are unchanged. After release, the next op to the same addr forwards the pre-stall result.
- Counter edges: with OVF_CNT_W=2, 5 overflows -> ovf_count sticks at 3. Assert ovf_clr together with an overflowing op -> ovf_count=0.
- Async reset: assert rst mid-burst, between clock edges -> all outputs 0 immediately. First op after release has fwd_hit_wb=0.

Source files
------------

// File: rtl/pe_acc_add_stage.sv
// PE add stage: out_act + mult with saturate/wrap, read-after-write forwarding
// from recent results, stall hold and a saturating overflow event counter.
module pe_acc_add_stage #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned OVF_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 sat_en,
  input  logic                 ovf_clr,
  input  logic                 comp_en_add,
  input  logic [DATA_W-1:0]    out_act_value_add,
  input  logic [DATA_W-1:0]    mult_result_add,
  input  logic [ADDR_W-1:0]    out_act_addr_add,
  output logic                 comp_en_wb,
  output logic [ADDR_W-1:0]    out_act_addr_wb,
  output logic [DATA_W-1:0]    add_result_wb,
  output logic                 overflow_wb,
  output logic                 fwd_hit_wb,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  localparam int unsigned SUM_W = DATA_W + 1;
  localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [OVF_CNT_W-1:0] CNT_MAX = {OVF_CNT_W{1'b1}};

  logic                accept_c;
  logic [FWD_DEPTH-1:0] hist_vld;
  logic [ADDR_W-1:0]   hist_addr [FWD_DEPTH];
  logic [DATA_W-1:0]   hist_data [FWD_DEPTH];

  logic [DATA_W-1:0]   opnd_a_c;
  logic                fwd_hit_c;
  logic [SUM_W-1:0]    sum_c;
  logic                ovf_c;
  logic [DATA_W-1:0]   result_c;

  assign accept_c = comp_en_add & ~stall;

  // Operand select: scan oldest to newest so the newest matching entry wins.
  always_comb begin
    opnd_a_c  = out_act_value_add;
    fwd_hit_c = 1'b0;
    for (int i = int'(FWD_DEPTH) - 1; i >= 0; i--) begin
      if (hist_vld[i] && (hist_addr[i] == out_act_addr_add)) begin
        opnd_a_c  = hist_data[i];
        fwd_hit_c = 1'b1;
      end
    end
  end

  // Signed add one bit wide; overflow when the two top bits disagree.
  always_comb begin
    sum_c    = {opnd_a_c[DATA_W-1], opnd_a_c} + {mult_result_add[DATA_W-1], mult_result_add};
    ovf_c    = sum_c[SUM_W-1] ^ sum_c[SUM_W-2];
    result_c = sum_c[DATA_W-1:0];
    if (ovf_c && sat_en) begin
      result_c = sum_c[SUM_W-1] ? MIN_VAL : MAX_VAL;
    end
  end

  // Write-back registers: pulse valid, hold payload on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp_en_wb      <= 1'b0;
      out_act_addr_wb <= '0;
      add_result_wb   <= '0;
      overflow_wb     <= 1'b0;
      fwd_hit_wb      <= 1'b0;
    end else if (!stall) begin
      comp_en_wb <= comp_en_add;
      if (comp_en_add) begin
        out_act_addr_wb <= out_act_addr_add;
        add_result_wb   <= result_c;
        overflow_wb     <= ovf_c;
        fwd_hit_wb      <= fwd_hit_c;
      end
    end
  end

  // History shifts every unstalled cycle; idle cycles shift in an invalid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FWD_DEPTH); i++) begin
        hist_vld[i]  <= 1'b0;
        hist_addr[i] <= '0;
        hist_data[i] <= '0;
      end
    end else if (!stall) begin
      for (int i = 1; i < int'(FWD_DEPTH); i++) begin
        hist_vld[i]  <= hist_vld[i-1];
        hist_addr[i] <= hist_addr[i-1];
        hist_data[i] <= hist_data[i-1];
      end
      hist_vld[0]  <= accept_c;
      hist_addr[0] <= out_act_addr_add;
      hist_data[0] <= result_c;
    end
  end

  // Clear wins over increment and also acts while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (ovf_clr) begin
      ovf_count <= '0;
    end else if (accept_c && ovf_c && (ovf_count != CNT_MAX)) begin
      ovf_count <= ovf_count + OVF_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pe_acc_add_stage.sv
// Self-checking bench for pe_acc_add_stage: directed vector table, stall and
// async-reset sequences, then random traffic against an arithmetic model.
module tb_pe_acc_add_stage;

  logic        clk = 1'b0;
  logic        rst, stall, sat_en, ovf_clr, comp_en_add;
  logic [15:0] val, mult;
  logic [5:0]  addr;

  logic        en_a, ovf_a, fwd_a;
  logic [5:0]  addr_a;
  logic [15:0] res_a, cnt_a;
  logic        en_b, ovf_b, fwd_b;
  logic [5:0]  addr_b;
  logic [15:0] res_b;
  logic [1:0]  cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pe_acc_add_stage #(.DATA_W(16), .ADDR_W(6), .FWD_DEPTH(2), .OVF_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .sat_en(sat_en), .ovf_clr(ovf_clr),
    .comp_en_add(comp_en_add), .out_act_value_add(val), .mult_result_add(mult),
    .out_act_addr_add(addr), .comp_en_wb(en_a), .out_act_addr_wb(addr_a),
    .add_result_wb(res_a), .overflow_wb(ovf_a), .fwd_hit_wb(fwd_a), .ovf_count(cnt_a));

  pe_acc_add_stage #(.DATA_W(16), .ADDR_W(6), .FWD_DEPTH(2), .OVF_CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .stall(stall), .sat_en(sat_en), .ovf_clr(ovf_clr),
    .comp_en_add(comp_en_add), .out_act_value_add(val), .mult_result_add(mult),
    .out_act_addr_add(addr), .comp_en_wb(en_b), .out_act_addr_wb(addr_b),
    .add_result_wb(res_b), .overflow_wb(ovf_b), .fwd_hit_wb(fwd_b), .ovf_count(cnt_b));

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int e_en, input int e_addr, input int e_res,
                         input int e_ovf, input int e_fwd, input int e_c16, input int e_c2);
    chk({tag, " comp_en_wb"}, longint'(en_a), e_en);
    chk({tag, " addr_wb"}, longint'(addr_a), e_addr);
    chk({tag, " add_result_wb"}, longint'($signed(res_a)), e_res);
    chk({tag, " overflow_wb"}, longint'(ovf_a), e_ovf);
    chk({tag, " fwd_hit_wb"}, longint'(fwd_a), e_fwd);
    chk({tag, " ovf_count"}, longint'(cnt_a), e_c16);
    chk({tag, " ovf_count_w2"}, longint'(cnt_b), e_c2);
  endtask

  task automatic drive(input bit st, input bit sat, input bit clr, input bit en,
                       input int v, input int m, input int a);
    stall = st; sat_en = sat; ovf_clr = clr; comp_en_add = en;
    val = 16'(v); mult = 16'(m); addr = 6'(a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hard_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit v; int a; int r; } hist_t;
  hist_t mh[$];
  int m_en, m_addr, m_res, m_ovf, m_fwd, m_c16, m_c2;

  function automatic void model_reset();
    mh.delete();
    m_en = 0; m_addr = 0; m_res = 0; m_ovf = 0; m_fwd = 0; m_c16 = 0; m_c2 = 0;
  endfunction

  function automatic void model_step(bit st, bit sat, bit clr, bit en, int v, int m, int a);
    hist_t e;
    int opa, sum, res, hit;
    if (st) begin
      if (clr) begin m_c16 = 0; m_c2 = 0; end
      return;
    end
    e.v = en; e.a = a; e.r = 0;
    if (en) begin
      opa = v; hit = 0;
      foreach (mh[i]) if (hit == 0 && mh[i].v && mh[i].a == a) begin opa = mh[i].r; hit = 1; end
      sum = opa + m;
      res = sum;
      m_ovf = (sum > 32767 || sum < -32768) ? 1 : 0;
      if (m_ovf != 0) res = sat ? ((sum > 0) ? 32767 : -32768) : (((sum + 32768) & 65535) - 32768);
      m_addr = a; m_res = res; m_fwd = hit; e.r = res;
      if (clr) begin m_c16 = 0; m_c2 = 0; end
      else if (m_ovf != 0) begin
        if (m_c16 < 65535) m_c16++;
        if (m_c2 < 3) m_c2++;
      end
    end else if (clr) begin
      m_c16 = 0; m_c2 = 0;
    end
    m_en = en;
    mh.push_front(e);
    while (mh.size() > 2) void'(mh.pop_back());
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit st, sat, clr, en;
    int v, m, a;
    int e_en, e_res, e_ovf, e_fwd, e_c16, e_c2;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(bit st, bit sat, bit clr, bit en, int v, int m, int a,
                              int e_en, int e_res, int e_ovf, int e_fwd, int e_c16, int e_c2);
    vec_t r;
    r.st = st; r.sat = sat; r.clr = clr; r.en = en; r.v = v; r.m = m; r.a = a;
    r.e_en = e_en; r.e_res = e_res; r.e_ovf = e_ovf; r.e_fwd = e_fwd; r.e_c16 = e_c16; r.e_c2 = e_c2;
    return r;
  endfunction

  initial begin
    int last_addr;
    bit st, sat, clr, en;
    int v, m, a;
    logic [15:0] r16;

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk_out("por", 0, 0, 0, 0, 0, 0, 0);
    hard_reset();

    vt.push_back(mk(0,1,0,1,   100,  25, 3, 1,   125, 0, 0, 0, 0));
    vt.push_back(mk(0,1,0,1,    -7,  -8, 5, 1,   -15, 0, 0, 0, 0));
    vt.push_back(mk(0,1,0,1,     0,  10, 9, 1,    10, 0, 0, 0, 0));
    vt.push_back(mk(0,1,0,1,     0,  20, 9, 1,    30, 0, 1, 0, 0));
    vt.push_back(mk(0,1,0,1,     0,  30, 9, 1,    60, 0, 1, 0, 0));
    vt.push_back(mk(0,1,0,0,     0,   0, 9, 0,    60, 0, 1, 0, 0));
    vt.push_back(mk(0,1,0,1,     0,   5, 9, 1,    65, 0, 1, 0, 0));
    vt.push_back(mk(0,1,0,0,     0,   0, 9, 0,    65, 0, 1, 0, 0));
    vt.push_back(mk(0,1,0,0,     0,   0, 9, 0,    65, 0, 1, 0, 0));
    vt.push_back(mk(0,1,0,1,   100,   5, 9, 1,   105, 0, 0, 0, 0));
    vt.push_back(mk(0,1,0,1, 32767,   1, 1, 1, 32767, 1, 0, 1, 1));
    vt.push_back(mk(0,1,0,1,-32768,  -1, 2, 1,-32768, 1, 0, 2, 2));
    vt.push_back(mk(0,0,0,1, 32767,   1, 4, 1,-32768, 1, 0, 3, 3));
    vt.push_back(mk(0,1,0,0,     0,   0, 4, 0,-32768, 1, 0, 3, 3));
    vt.push_back(mk(0,1,0,1, 32767,   1,10, 1, 32767, 1, 0, 4, 3));
    vt.push_back(mk(0,1,0,1, 32767,   1,11, 1, 32767, 1, 0, 5, 3));
    vt.push_back(mk(0,1,1,1, 32767,   1,12, 1, 32767, 1, 0, 0, 0));
    vt.push_back(mk(0,1,0,1,     1,   1,13, 1,     2, 0, 0, 0, 0));

    last_addr = 0;
    foreach (vt[i]) begin
      drive(vt[i].st, vt[i].sat, vt[i].clr, vt[i].en, vt[i].v, vt[i].m, vt[i].a);
      if (vt[i].en) last_addr = vt[i].a;
      tick();
      chk_out($sformatf("vec%0d", i), vt[i].e_en, last_addr, vt[i].e_res,
              vt[i].e_ovf, vt[i].e_fwd, vt[i].e_c16, vt[i].e_c2);
    end

    // Stall: outputs and history frozen while inputs churn.
    drive(0, 1, 0, 1, 7, 3, 20);
    tick();
    chk_out("stall_pre", 1, 20, 10, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, k[0], 0, 1, 32767 - k, 100 + k, k);
      tick();
      chk_out($sformatf("stall%0d", k), 1, 20, 10, 0, 0, 0, 0);
    end
    drive(0, 1, 0, 1, 0, 1, 20);
    tick();
    chk_out("stall_post", 1, 20, 11, 0, 1, 0, 0);

    // Async reset asserted between edges.
    drive(0, 1, 0, 1, 40, 2, 30);
    tick();
    chk_out("rst_pre", 1, 30, 42, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 9, 9, 30);
    #2;
    rst = 1'b1;
    #1;
    chk_out("rst_async", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_out("rst_idle", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 50, 1, 30);
    tick();
    chk_out("rst_first", 1, 30, 51, 0, 0, 0, 0);

    // Random traffic against the model.
    hard_reset();
    model_reset();
    for (int k = 0; k < 3000; k++) begin
      st  = ($urandom_range(0, 4) == 0);
      sat = $urandom_range(0, 1);
      clr = ($urandom_range(0, 19) == 0);
      en  = ($urandom_range(0, 9) < 7);
      a   = int'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: v = 32767;
        1: v = -32768;
        2: v = int'($urandom_range(0, 200)) - 100;
        default: begin r16 = 16'($urandom); v = int'($signed(r16)); end
      endcase
      case ($urandom_range(0, 2))
        0: m = int'($urandom_range(0, 20)) - 10;
        default: begin r16 = 16'($urandom); m = int'($signed(r16)); end
      endcase
      model_step(st, sat, clr, en, v, m, a);
      drive(st, sat, clr, en, v, m, a);
      tick();
      chk_out($sformatf("rnd%0d", k), m_en, m_addr, m_res, m_ovf, m_fwd, m_c16, m_c2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
